// File: rtl/mesm6_pic_pkg.sv
// rtl/mesm6_pic_pkg.sv - shared constants and types for the mesm6 interrupt controller and entry sequencer
package mesm6_pic_pkg;

    localparam int NUM_SRC = 48;

    // Register map of the interrupt controller (only 3 address bits decode)
    localparam logic [2:0] ADDR_IFS    = 3'o7;
    localparam logic [2:0] ADDR_IFSSET = 3'o6;
    localparam logic [2:0] ADDR_IFSCLR = 3'o5;
    localparam logic [2:0] ADDR_IEC    = 3'o4;
    localparam logic [2:0] ADDR_IECSET = 3'o3;
    localparam logic [2:0] ADDR_IECCLR = 3'o2;
    localparam logic [2:0] ADDR_OFF    = 3'o0;

    typedef enum logic [3:0] {
        IDLE,
        RD_IFS,
        GAP_A,
        RD_IEC,
        GAP_B,
        PICK,
        CLR,
        GAP_C,
        REQ
    } seq_state_e;

    // Source number 1..48 back to its flag bit (number 1 is bit 47); 0 gives no bit
    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [5:0] num);
        logic [NUM_SRC-1:0] oh;
        oh = '0;
        if (num != 6'd0 && num <= 6'(NUM_SRC)) begin
            oh = {{(NUM_SRC-1){1'b0}}, 1'b1} << (6'(NUM_SRC) - num);
        end
        return oh;
    endfunction

endpackage

// File: rtl/mesm6_prio48.sv
// rtl/mesm6_prio48.sv - 48-bit priority encoder, bit 47 highest, result 1..48 or 0 when empty
module mesm6_prio48
    import mesm6_pic_pkg::*;
(
    input  logic [NUM_SRC-1:0] vec,
    output logic [5:0]         num
);

    // Scan upward so the highest set bit is the last (winning) assignment
    always_comb begin
        num = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (vec[i]) begin
                num = 6'(NUM_SRC - i);
            end
        end
    end

endmodule

// File: rtl/mesm6_irq_seq.sv
// rtl/mesm6_irq_seq.sv - interrupt entry sequencer: read IFS/IEC, pick, clear flag, hand vector to CPU
module mesm6_irq_seq
    import mesm6_pic_pkg::*;
#(
    parameter logic [14:0] VEC_BASE   = 15'o100,
    parameter int          VEC_STRIDE = 2,
    parameter int          TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    input  logic        irq_enable,
    output logic [14:0] pic_addr,
    output logic        pic_read,
    output logic        pic_write,
    output logic [47:0] pic_wdata,
    input  logic [47:0] pic_rdata,
    input  logic        pic_done,
    output logic        irq_req,
    output logic [5:0]  irq_num,
    output logic [14:0] irq_vector,
    input  logic        irq_ack,
    output logic        bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_e         state_q, state_d;
    logic [47:0]        ifs_q, ifs_d;
    logic [47:0]        iec_q, iec_d;
    logic [5:0]         irq_num_q, irq_num_d;
    logic [14:0]        irq_vector_q, irq_vector_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bus_err_q, bus_err_d;
    logic [5:0]         pick_num;
    logic               timeout_hit;

    function automatic logic [14:0] vec_of(input logic [5:0] num);
        return 15'(int'(VEC_BASE) + (int'(num) - 1) * VEC_STRIDE);
    endfunction

    mesm6_prio48 u_prio (
        .vec (ifs_q & iec_q),
        .num (pick_num)
    );

    // Wait counter has seen TIMEOUT cycles in the current bus state by the next edge
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State, captured registers and timeout counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ifs_q        <= '0;
            iec_q        <= '0;
            irq_num_q    <= '0;
            irq_vector_q <= '0;
            cnt_q        <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ifs_q        <= ifs_d;
            iec_q        <= iec_d;
            irq_num_q    <= irq_num_d;
            irq_vector_q <= irq_vector_d;
            cnt_q        <= cnt_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Next state; counter clears whenever a bus state is left so each entry starts at zero
    always_comb begin
        state_d      = state_q;
        ifs_d        = ifs_q;
        iec_d        = iec_q;
        irq_num_d    = irq_num_q;
        irq_vector_d = irq_vector_q;
        cnt_d        = '0;
        bus_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (interrupt && irq_enable) begin
                    state_d = RD_IFS;
                end
            end
            RD_IFS: begin
                if (pic_done) begin
                    ifs_d   = pic_rdata;
                    state_d = GAP_A;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP_A: state_d = RD_IEC;
            RD_IEC: begin
                if (pic_done) begin
                    iec_d   = pic_rdata;
                    state_d = GAP_B;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP_B: state_d = PICK;
            PICK: begin
                if (pick_num == 6'd0) begin
                    state_d = IDLE;
                end else begin
                    irq_num_d    = pick_num;
                    irq_vector_d = vec_of(pick_num);
                    state_d      = CLR;
                end
            end
            CLR: begin
                if (pic_done) begin
                    state_d = GAP_C;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP_C: state_d = REQ;
            REQ: begin
                if (irq_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus and CPU outputs decoded purely from registered state and latched values
    always_comb begin
        pic_addr  = '0;
        pic_read  = 1'b0;
        pic_write = 1'b0;
        pic_wdata = '0;
        case (state_q)
            RD_IFS: begin
                pic_read = 1'b1;
                pic_addr = {12'd0, ADDR_IFS};
            end
            RD_IEC: begin
                pic_read = 1'b1;
                pic_addr = {12'd0, ADDR_IEC};
            end
            CLR: begin
                pic_write = 1'b1;
                pic_addr  = {12'd0, ADDR_IFSCLR};
                pic_wdata = src_onehot(irq_num_q);
            end
            default: ;
        endcase
    end

    assign irq_req    = (state_q == REQ);
    assign irq_num    = irq_num_q;
    assign irq_vector = irq_vector_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mesm6_irq_seq.sv
// tb/tb_mesm6_irq_seq.sv - self-checking bench for mesm6_irq_seq against a controller model
module tb_mesm6_irq_seq;

    localparam int TIMEOUT    = 15;
    localparam int VEC_BASE   = 64;
    localparam int VEC_STRIDE = 2;
    localparam logic [47:0] ALL_ONES = {48{1'b1}};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        interrupt;
    logic        irq_enable = 1'b0;
    logic [14:0] pic_addr;
    logic        pic_read;
    logic        pic_write;
    logic [47:0] pic_wdata;
    logic [47:0] pic_rdata;
    logic        pic_done = 1'b0;
    logic        irq_req;
    logic [5:0]  irq_num;
    logic [14:0] irq_vector;
    logic        irq_ack = 1'b0;
    logic        bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mesm6_irq_seq #(
        .VEC_BASE   (15'o100),
        .VEC_STRIDE (VEC_STRIDE),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .interrupt  (interrupt),
        .irq_enable (irq_enable),
        .pic_addr   (pic_addr),
        .pic_read   (pic_read),
        .pic_write  (pic_write),
        .pic_wdata  (pic_wdata),
        .pic_rdata  (pic_rdata),
        .pic_done   (pic_done),
        .irq_req    (irq_req),
        .irq_num    (irq_num),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack),
        .bus_err    (bus_err)
    );

    // Controller model: IFS/IEC registers, done after resp_lat cycles of request, IFSCLR clears bits
    logic [47:0] ifs_r = '0;
    logic [47:0] iec_r = '0;
    logic        load_en = 1'b0;
    logic        load_iec_en = 1'b0;
    logic [47:0] load_ifs = '0;
    logic [47:0] load_iec = '0;
    int          resp_lat = 1;
    bit          stall = 1'b0;
    int          wait_cnt = 0;

    assign interrupt = |(ifs_r & iec_r);
    assign pic_rdata = (pic_addr == 15'o7) ? ifs_r : (pic_addr == 15'o4) ? iec_r : 48'd0;

    always @(posedge clk) begin
        pic_done <= 1'b0;
        if ((pic_read || pic_write) && !stall) begin
            if (wait_cnt >= resp_lat - 1) begin
                pic_done <= 1'b1;
                wait_cnt <= 0;
                if (pic_write && pic_addr == 15'o5) ifs_r <= ifs_r & ~pic_wdata;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
        if (load_en) begin
            ifs_r <= load_ifs;
            iec_r <= load_iec;
        end else if (load_iec_en) begin
            iec_r <= load_iec;
        end
    end

    // Monitor: count write transactions, irq_req rises and bus_err cycles
    int          n_wr = 0;
    int          n_req = 0;
    int          n_berr = 0;
    logic [14:0] wr_addr = '0;
    logic [47:0] wr_data = '0;
    logic        prev_wr = 1'b0;
    logic        prev_req = 1'b0;

    always @(negedge clk) begin
        if (pic_write && !prev_wr) begin
            n_wr    = n_wr + 1;
            wr_addr = pic_addr;
            wr_data = pic_wdata;
        end
        if (irq_req && !prev_req) n_req = n_req + 1;
        if (bus_err) n_berr = n_berr + 1;
        prev_wr  = pic_write;
        prev_req = irq_req;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Highest set bit of a mask, -1 when empty
    function automatic int ref_top(input logic [47:0] m);
        for (int i = 47; i >= 0; i--) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    // Called at a negedge; new register values land on the next posedge, returns one negedge later
    task automatic load_regs(input logic [47:0] ifs, input logic [47:0] iec);
        load_ifs = ifs;
        load_iec = iec;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic run_entry(input string tag, input logic [47:0] ifs, input logic [47:0] iec,
                             input int lat, input int ack_dly, input bit drop_en);
        int          idx, k, unstable, wr0, req0;
        logic [5:0]  exp_num, held_num;
        logic [14:0] exp_vec, held_vec;
        logic [47:0] exp_oh;
        idx     = ref_top(ifs & iec);
        exp_num = 6'(48 - idx);
        exp_vec = 15'(VEC_BASE + (48 - idx - 1) * VEC_STRIDE);
        exp_oh  = '0;
        exp_oh[idx] = 1'b1;
        resp_lat   = lat;
        irq_enable = 1'b1;
        wr0  = n_wr;
        req0 = n_req;
        load_regs(ifs, iec);
        k = 0;
        while (!irq_req && k < 300) begin
            @(negedge clk);
            k++;
            if (drop_en && pic_read && pic_addr == 15'o4) irq_enable = 1'b0;
        end
        // 1 cycle for interrupt to be sampled, 3 transactions of lat+1, 3 gaps, 1 pick
        check_eq({tag, ":latency"}, 64'(k), 64'(3 * lat + 8));
        check_eq({tag, ":irq_num"}, 64'(irq_num), 64'(exp_num));
        check_eq({tag, ":irq_vector"}, 64'(irq_vector), 64'(exp_vec));
        check_eq({tag, ":writes"}, 64'(n_wr - wr0), 64'd1);
        check_eq({tag, ":wr_addr"}, 64'(wr_addr), 64'o5);
        check_eq({tag, ":wr_data"}, 64'(wr_data), 64'(exp_oh));
        held_num = irq_num;
        held_vec = irq_vector;
        unstable = 0;
        repeat (ack_dly) begin
            @(negedge clk);
            if (!irq_req || irq_num !== held_num || irq_vector !== held_vec) unstable++;
        end
        irq_ack    = 1'b1;
        irq_enable = 1'b0;
        @(negedge clk);
        irq_ack = 1'b0;
        check_eq({tag, ":req_hold"}, 64'(unstable), 64'd0);
        check_eq({tag, ":req_drop"}, 64'(irq_req), 64'd0);
        check_eq({tag, ":ifs_after"}, 64'(ifs_r), 64'(ifs & ~exp_oh));
        check_eq({tag, ":req_count"}, 64'(n_req - req0), 64'd1);
        load_regs('0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          k, wr0, req0, be0, kind;
        logic [63:0] r;
        logic [47:0] ifs, iec;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst:pic_read", 64'(pic_read), 64'd0);
        check_eq("rst:pic_write", 64'(pic_write), 64'd0);
        check_eq("rst:pic_addr", 64'(pic_addr), 64'd0);
        check_eq("rst:pic_wdata", 64'(pic_wdata), 64'd0);
        check_eq("rst:irq_req", 64'(irq_req), 64'd0);
        check_eq("rst:irq_num", 64'(irq_num), 64'd0);
        check_eq("rst:irq_vector", 64'(irq_vector), 64'd0);
        check_eq("rst:bus_err", 64'(bus_err), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single source, masked priority
        run_entry("single", 48'h8, ALL_ONES, 1, 0, 1'b0);
        run_entry("masked", 48'h8000_0000_0400, 48'h400, 1, 2, 1'b0);

        // Race: IEC cleared after the IFS read has started
        resp_lat   = 1;
        irq_enable = 1'b1;
        wr0 = n_wr; req0 = n_req; be0 = n_berr;
        load_regs(48'h8, ALL_ONES);
        k = 0;
        while (!(pic_read && pic_addr == 15'o7) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("race:rd_ifs_seen", 64'(k < 50), 64'd1);
        load_iec    = '0;
        load_iec_en = 1'b1;
        @(negedge clk);
        load_iec_en = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("race:writes", 64'(n_wr - wr0), 64'd0);
        check_eq("race:reqs", 64'(n_req - req0), 64'd0);
        check_eq("race:bus_err", 64'(n_berr - be0), 64'd0);
        check_eq("race:idle", 64'(pic_read | pic_write), 64'd0);
        check_eq("race:ifs_kept", 64'(ifs_r), 64'h8);
        irq_enable = 1'b0;
        load_regs('0, '0);

        // Stalled responder: bus_err exactly TIMEOUT cycles after RD_IFS entry
        stall      = 1'b1;
        irq_enable = 1'b1;
        be0 = n_berr; req0 = n_req;
        load_regs(48'h1, 48'h1);
        k = 0;
        while (!pic_read && k < 50) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (!bus_err && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("stall:bus_err_time", 64'(k), 64'(TIMEOUT));
        check_eq("stall:read_dropped", 64'(pic_read), 64'd0);
        irq_enable = 1'b0;
        @(negedge clk);
        check_eq("stall:bus_err_pulse", 64'(bus_err), 64'd0);
        check_eq("stall:idle", 64'(pic_read | pic_write), 64'd0);
        check_eq("stall:bus_err_count", 64'(n_berr - be0), 64'd1);
        check_eq("stall:no_req", 64'(n_req - req0), 64'd0);
        stall = 1'b0;
        load_regs('0, '0);

        // Asynchronous reset during CLR, then clean restart
        resp_lat   = 3;
        irq_enable = 1'b1;
        load_regs(48'h8, ALL_ONES);
        k = 0;
        while (!pic_write && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("rstmid:clr_seen", 64'(k < 100), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("rstmid:pic_write", 64'(pic_write), 64'd0);
        check_eq("rstmid:pic_addr", 64'(pic_addr), 64'd0);
        check_eq("rstmid:pic_wdata", 64'(pic_wdata), 64'd0);
        check_eq("rstmid:irq_num", 64'(irq_num), 64'd0);
        check_eq("rstmid:irq_vector", 64'(irq_vector), 64'd0);
        check_eq("rstmid:outs", 64'({pic_read, irq_req, bus_err}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rstmid:restart_read", 64'(pic_read), 64'd1);
        check_eq("rstmid:restart_addr", 64'(pic_addr), 64'o7);
        check_eq("rstmid:ifs_kept", 64'(ifs_r), 64'h8);
        k = 0;
        while (!irq_req && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("rstmid:irq_num_after", 64'(irq_num), 64'd45);
        irq_ack    = 1'b1;
        irq_enable = 1'b0;
        @(negedge clk);
        irq_ack = 1'b0;
        check_eq("rstmid:ifs_cleared", 64'(ifs_r), 64'd0);
        load_regs('0, '0);

        // Held ack with irq_enable dropped during RD_IEC
        run_entry("held_ack", 48'h10_0020, ALL_ONES, 1, 20, 1'b1);

        // Randomized entries
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 2);
            r    = {$urandom, $urandom};
            case (kind)
                0:       ifs = 48'd1 << $urandom_range(0, 47);
                1:       ifs = (48'd1 << $urandom_range(0, 47)) | (48'd1 << $urandom_range(0, 47));
                default: ifs = r[47:0];
            endcase
            r   = {$urandom, $urandom};
            iec = $urandom_range(0, 1) ? ALL_ONES : r[47:0];
            if ((ifs & iec) == '0) iec = iec | ifs;
            run_entry($sformatf("rand%0d", it), ifs, iec, $urandom_range(1, 4),
                      $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
